// File: rtl/opcode_pkg.sv
// opcode_pkg: shared state encoding, widths and helpers for the opcode injector.
package opcode_pkg;

   localparam int         STATE_W       = 3;
   localparam int         CNT_W         = 8;
   localparam int         VEC_W         = 16;
   localparam logic [7:0] JP_OPCODE_DEF = 8'hC3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_OP    = 3'd2,
      ST_GAP1  = 3'd3,
      ST_LO    = 3'd4,
      ST_GAP2  = 3'd5,
      ST_HI    = 3'd6
   } state_e;

   // True in the three states that own the Z80 data bus.
   function automatic logic is_drive_state(input state_e s);
      return (s == ST_OP) || (s == ST_LO) || (s == ST_HI);
   endfunction

   // Byte presented on the bus for a given state; zero when not driving.
   function automatic logic [7:0] drive_byte(input state_e           s,
                                             input logic [7:0]       opc,
                                             input logic [VEC_W-1:0] vec);
      logic [7:0] b;
      b = 8'h00;
      case (s)
         ST_OP:   b = opc;
         ST_LO:   b = vec[7:0];
         ST_HI:   b = vec[15:8];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/bus_sync.sv
// bus_sync: multi-flop synchronizer for one asynchronous Z80 strobe, plus a
// one-clk-delayed copy so the consumer can detect changes between clks.
module bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic sync_o,
   output logic prev_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   prev_q;

   // Shift the raw strobe into the chain, oldest sample at the top.
   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = async_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   // Chain and edge-detect flop; strobes are active-low so they idle at 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sync_o = sync_q[SYNC_STAGES-1];
   assign prev_o = prev_q;

endmodule

// File: rtl/opcode_inject.sv
// opcode_inject: forces a Z80 to execute "JP vec" by substituting the opcode
// and both operand bytes of the next instruction fetch after a trap request.
module opcode_inject
   import opcode_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] JP_OPCODE   = JP_OPCODE_DEF,
   parameter int         TIMEOUT     = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m1_n,
   input  logic        mreq_n,
   input  logic        rd_n,
   input  logic        at_isr_end,
   input  logic        trap_req,
   input  logic [15:0] trap_vec,
   output logic [7:0]  data_out,
   output logic        data_oe,
   output logic        mem_inhibit,
   output logic        busy,
   output logic        trap_ack,
   output logic        trap_err
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   logic m1_s, mreq_s, rd_s;
   logic mreq_p, rd_p;
   logic m1_prev_unused;

   logic rd_act, rd_act_prev;
   logic rd_start, rd_end;
   logic fetch_start, oper_start;

   state_e             state_q, state_d;
   logic [VEC_W-1:0]   vec_q, vec_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ack_q, ack_d;
   logic               err_q, err_d;

   bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_m1 (
      .clk     (clk),
      .rst     (rst),
      .async_i (m1_n),
      .sync_o  (m1_s),
      .prev_o  (m1_prev_unused)
   );

   bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mreq (
      .clk     (clk),
      .rst     (rst),
      .async_i (mreq_n),
      .sync_o  (mreq_s),
      .prev_o  (mreq_p)
   );

   bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
      .clk     (clk),
      .rst     (rst),
      .async_i (rd_n),
      .sync_o  (rd_s),
      .prev_o  (rd_p)
   );

   // A read needs both MREQ and RD low, so interrupt acknowledge (no MREQ)
   // and refresh (no RD) never qualify. M1 is looked at only on the start.
   always_comb begin
      rd_act      = ~mreq_s & ~rd_s;
      rd_act_prev = ~mreq_p & ~rd_p;
      rd_start    = rd_act & ~rd_act_prev;
      rd_end      = ~rd_act & rd_act_prev;
      fetch_start = rd_start & ~m1_s;
      oper_start  = rd_start & m1_s;
   end

   // Next-state logic: walks opcode, low byte, high byte with timed gaps.
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (trap_req) begin
               vec_d   = trap_vec;
               state_d = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (fetch_start && at_isr_end) begin
               state_d = ST_OP;
            end
         end
         ST_OP: begin
            if (rd_end) begin
               state_d = ST_GAP1;
               cnt_d   = '0;
            end
         end
         ST_GAP1: begin
            if (oper_start) begin
               state_d = ST_LO;
            end else if (fetch_start || (cnt_q == TIMEOUT_C)) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_LO: begin
            if (rd_end) begin
               state_d = ST_GAP2;
               cnt_d   = '0;
            end
         end
         ST_GAP2: begin
            if (oper_start) begin
               state_d = ST_HI;
            end else if (fetch_start || (cnt_q == TIMEOUT_C)) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_HI: begin
            if (rd_end) begin
               state_d = ST_IDLE;
               ack_d   = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, latched vector, gap counter and the ack/err pulse flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   // Bus drive is decoded straight from the state register so that a reset
   // releases the bus on the same edge it takes effect.
   always_comb begin
      data_oe     = is_drive_state(state_q);
      mem_inhibit = is_drive_state(state_q);
      data_out    = drive_byte(state_q, JP_OPCODE, vec_q);
      busy        = (state_q != ST_IDLE);
      trap_ack    = ack_q;
      trap_err    = err_q;
   end

endmodule
